// File: rtl/idelay_multi_set_ctrl.sv
// Shared sequencer that walks NCH IDELAY tap values toward their targets in bounded steps.
// Define IDELAY_VERIFY_EN to add the sticky readback check (verify_err_o).
module idelay_multi_set_ctrl #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned W        = 9,
    parameter int unsigned MAX_STEP = 8,
    parameter int unsigned SETTLE   = 4
) (
    input  logic             clk160_i,
    input  logic             rstb_i,
    input  logic [NCH*W-1:0] delay_target_i,
    input  logic [NCH*W-1:0] delay_out_i,
    output logic [NCH*W-1:0] delay_set_value_o,
    output logic [NCH-1:0]   delay_wr_o,
    output logic [NCH-1:0]   delay_ready_o,
    output logic             all_ready_o,
    output logic             busy_o,
    output logic [NCH-1:0]   verify_err_o,
    input  logic             err_clr_i
);
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam logic [PW-1:0] PtrLast = PW'(NCH - 1);
    localparam logic [CW-1:0] CntLoad = CW'(SETTLE - 1);
    localparam logic [W:0] StepMaxU = (W + 1)'(MAX_STEP);

    typedef enum logic [2:0] {StIdle, StCapture, StCalc, StWrite, StSettle} state_e;

    state_e           state_q;
    logic [PW-1:0]    ptr_q;
    logic [W-1:0]     rd_hold_q;
    logic [W-1:0]     wr_hold_q;
    logic [CW-1:0]    cnt_q;
    logic [NCH*W-1:0] set_q;
    logic [NCH-1:0]   wr_q;
    logic             busy_q;

    logic [PW-1:0]    ptr_next;
    logic [W-1:0]     out_sel;
    logic [W-1:0]     tgt_sel;
    logic signed [W:0] diff;
    logic signed [W:0] step;
    logic [W:0]       diff_abs;
    logic [W-1:0]     calc_val;

    for (genvar c = 0; c < NCH; c++) begin : g_ready
        assign delay_ready_o[c] = (delay_target_i[c*W +: W] == delay_out_i[c*W +: W]);
    end
    assign all_ready_o = &delay_ready_o;

    always_comb begin
        ptr_next = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
        out_sel  = delay_out_i[ptr_q*W +: W];
        tgt_sel  = delay_target_i[ptr_q*W +: W];
        diff     = $signed({1'b0, wr_hold_q}) - $signed({1'b0, rd_hold_q});
        diff_abs = diff[W] ? unsigned'(-diff) : unsigned'(diff);
        step     = diff;
        if (MAX_STEP != 0 && diff_abs >= StepMaxU) begin
            step = diff[W] ? -$signed(StepMaxU) : $signed(StepMaxU);
        end
        // Target is always in range, so the clamped sum never wraps.
        calc_val = rd_hold_q + step[W-1:0];
    end

`ifdef IDELAY_VERIFY_EN
    logic [NCH-1:0] err_q;
    logic           verify_hit;

    assign verify_hit = (state_q == StSettle) && (cnt_q == '0) &&
                        (out_sel != set_q[ptr_q*W +: W]);

    always_ff @(posedge clk160_i) begin
        if (!rstb_i) begin
            err_q <= '0;
        end else begin
            if (err_clr_i) err_q <= '0;
            if (verify_hit) err_q[ptr_q] <= 1'b1;
        end
    end
    assign verify_err_o = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign verify_err_o   = '0;
`endif

    always_ff @(posedge clk160_i) begin
        if (!rstb_i) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            rd_hold_q <= '0;
            wr_hold_q <= '0;
            cnt_q     <= '0;
            set_q     <= '0;
            wr_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            wr_q <= '0;
            case (state_q)
                StIdle: begin
                    if (!delay_ready_o[ptr_q]) begin
                        state_q <= StCapture;
                        busy_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_next;
                    end
                end
                StCapture: begin
                    rd_hold_q <= out_sel;
                    wr_hold_q <= tgt_sel;
                    state_q   <= StCalc;
                end
                StCalc: begin
                    set_q[ptr_q*W +: W] <= calc_val;
                    wr_q[ptr_q]         <= 1'b1;
                    state_q             <= StWrite;
                end
                StWrite: begin
                    cnt_q   <= CntLoad;
                    state_q <= StSettle;
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        ptr_q   <= ptr_next;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign delay_set_value_o = set_q;
    assign delay_wr_o        = wr_q;
    assign busy_o            = busy_q;
endmodule

// File: tb/tb_idelay_multi_set_ctrl.sv
// Bench for idelay_multi_set_ctrl: clamped instance (u0) and unlimited-step instance (u1),
// checked every cycle against a timeline model, plus literal strobe sequences.
module tb_idelay_multi_set_ctrl;
    localparam int NCH = 4;
    localparam int W = 9;
    localparam int SETTLE = 4;
`ifdef IDELAY_VERIFY_EN
    localparam logic EXP_V = 1'b1;
`else
    localparam logic EXP_V = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstb, err_clr;
    logic [NCH*W-1:0] tgt[2], outv[2], setv[2], rand_out[2], v1[2], v2[2];
    logic [NCH-1:0] wr[2], rdy[2], verr[2], p1[2], p2[2];
    logic allr[2], busy[2];
    logic [NCH-1:0] ig0;

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic m_valid = 1'b0;
    int m_k[2], m_ptr[2], m_rd[2], m_tv[2];
    int m_set[2][NCH];
    logic [NCH-1:0] m_wr[2], m_err[2];
    logic m_busy[2];
    int lg_inst[$], lg_ch[$], lg_val[$], lg_cyc[$];
    int g_ch[16], g_val[16], g_cyc[16];
    int g_n;

    always #5 clk = ~clk;

    idelay_multi_set_ctrl #(.NCH(NCH), .W(W), .MAX_STEP(8), .SETTLE(SETTLE)) u0 (
        .clk160_i(clk), .rstb_i(rstb), .delay_target_i(tgt[0]), .delay_out_i(outv[0]),
        .delay_set_value_o(setv[0]), .delay_wr_o(wr[0]), .delay_ready_o(rdy[0]),
        .all_ready_o(allr[0]), .busy_o(busy[0]), .verify_err_o(verr[0]), .err_clr_i(err_clr)
    );
    idelay_multi_set_ctrl #(.NCH(NCH), .W(W), .MAX_STEP(0), .SETTLE(SETTLE)) u1 (
        .clk160_i(clk), .rstb_i(rstb), .delay_target_i(tgt[1]), .delay_out_i(outv[1]),
        .delay_set_value_o(setv[1]), .delay_wr_o(wr[1]), .delay_ready_o(rdy[1]),
        .all_ready_o(allr[1]), .busy_o(busy[1]), .verify_err_o(verr[1]), .err_clr_i(err_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: k counts cycles since a channel was found not ready.
    task automatic model_step(input int i, input int ms);
        int d, a, p;
        if (!rstb) begin
            m_valid = 1'b1;
            m_k[i] = 0; m_ptr[i] = 0; m_rd[i] = 0; m_tv[i] = 0;
            m_wr[i] = '0; m_err[i] = '0; m_busy[i] = 1'b0;
            for (int c = 0; c < NCH; c++) m_set[i][c] = 0;
            return;
        end
        p = m_ptr[i];
        m_wr[i] = '0;
`ifdef IDELAY_VERIFY_EN
        if (err_clr) m_err[i] = '0;
`endif
        if (m_k[i] == 0) begin
            if (tgt[i][p*W +: W] != outv[i][p*W +: W]) begin
                m_k[i] = 1;
                m_busy[i] = 1'b1;
            end else begin
                m_ptr[i] = (p + 1) % NCH;
            end
        end else begin
            if (m_k[i] == 1) begin
                m_rd[i] = int'(outv[i][p*W +: W]);
                m_tv[i] = int'(tgt[i][p*W +: W]);
            end else if (m_k[i] == 2) begin
                d = m_tv[i] - m_rd[i];
                a = (d < 0) ? -d : d;
                if (ms == 0 || a < ms) m_set[i][p] = m_tv[i];
                else m_set[i][p] = (d < 0) ? m_rd[i] - ms : m_rd[i] + ms;
                m_wr[i][p] = 1'b1;
            end
            if (m_k[i] == 3 + SETTLE) begin
`ifdef IDELAY_VERIFY_EN
                if (int'(outv[i][p*W +: W]) != m_set[i][p]) m_err[i][p] = 1'b1;
`endif
                m_k[i] = 0;
                m_busy[i] = 1'b0;
                m_ptr[i] = (p + 1) % NCH;
            end else begin
                m_k[i]++;
            end
        end
    endtask

    task automatic tick();
        logic [NCH*W-1:0] e;
        logic [NCH-1:0] er;
        @(posedge clk);
        cyc++;
        model_step(0, 8);
        model_step(1, 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (m_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    e[c*W +: W] = W'(m_set[i][c]);
                    er[c] = (tgt[i][c*W +: W] == outv[i][c*W +: W]);
                end
                chk($sformatf("u%0d.set_value", i), 64'(setv[i]), 64'(e));
                chk($sformatf("u%0d.wr", i), 64'(wr[i]), 64'(m_wr[i]));
                chk($sformatf("u%0d.busy", i), 64'(busy[i]), 64'(m_busy[i]));
                chk($sformatf("u%0d.verify_err", i), 64'(verr[i]), 64'(m_err[i]));
                chk($sformatf("u%0d.ready", i), 64'(rdy[i]), 64'(er));
                chk($sformatf("u%0d.all_ready", i), 64'(allr[i]), 64'(&er));
            end
            for (int c = 0; c < NCH; c++) begin
                if (wr[i][c] === 1'b1) begin
                    lg_inst.push_back(i); lg_ch.push_back(c);
                    lg_val.push_back(int'(setv[i][c*W +: W])); lg_cyc.push_back(cyc);
                end
            end
            // Primitive: tap value follows a write two cycles later.
            if (!rstb) begin
                outv[i] = rand_out[i]; p1[i] = '0; p2[i] = '0;
            end else begin
                for (int c = 0; c < NCH; c++)
                    if (p2[i][c] && !(i == 0 && ig0[c])) outv[i][c*W +: W] = v2[i][c*W +: W];
                p2[i] = p1[i]; v2[i] = v1[i]; p1[i] = wr[i]; v1[i] = setv[i];
            end
        end
    endtask

    task automatic do_reset(output int r);
        rstb = 1'b0;
        repeat (3) tick();
        rstb = 1'b1;
        r = cyc;
        lg_inst.delete(); lg_ch.delete(); lg_val.delete(); lg_cyc.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(allr[0] && allr[1] && !busy[0] && !busy[1]) && n < 400);
        chk(name, 64'(n < 400), 64'd1);
    endtask

    task automatic wait_log(input int inst, input int ch, input int from, output int idx);
        int n = 0;
        idx = -1;
        while (idx < 0 && n < 300) begin
            for (int k = from; k < lg_ch.size(); k++)
                if (idx < 0 && lg_inst[k] == inst && lg_ch[k] == ch) idx = k;
            if (idx < 0) begin
                tick();
                n++;
            end
        end
        chk($sformatf("wait_log u%0d ch%0d", inst, ch), 64'(idx >= 0), 64'd1);
    endtask

    task automatic collect(input int inst);
        g_n = 0;
        for (int k = 0; k < 16; k++) begin g_ch[k] = -1; g_val[k] = -1; g_cyc[k] = -1; end
        for (int k = 0; k < lg_ch.size(); k++)
            if (lg_inst[k] == inst && g_n < 16) begin
                g_ch[g_n] = lg_ch[k]; g_val[g_n] = lg_val[k]; g_cyc[g_n] = lg_cyc[k];
                g_n++;
            end
    endtask

    initial begin
        int r, r2, idx, l0;
        int eb_ch[5] = '{0, 2, 0, 2, 0};
        int eb_val[5] = '{8, 92, 16, 90, 20};
        int eb_off[5] = '{3, 12, 21, 30, 39};
        int ec_ch[6] = '{1, 3, 1, 3, 1, 3};
        int ec_val[6] = '{8, 8, 16, 16, 24, 24};
        rstb = 1'b0; err_clr = 1'b0; ig0 = '0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NCH; c++) begin
                rand_out[i][c*W +: W] = W'($urandom_range(0, 511));
                tgt[i][c*W +: W] = W'($urandom_range(0, 511));
            end
            outv[i] = rand_out[i]; p1[i] = '0; p2[i] = '0; v1[i] = '0; v2[i] = '0;
        end

        // Reset with random inputs, then release with targets already met.
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst u%0d set_value", i), 64'(setv[i]), 64'd0);
            chk($sformatf("rst u%0d wr", i), 64'(wr[i]), 64'd0);
            chk($sformatf("rst u%0d busy", i), 64'(busy[i]), 64'd0);
            chk($sformatf("rst u%0d verify_err", i), 64'(verr[i]), 64'd0);
            tgt[i] = rand_out[i];
        end
        rstb = 1'b1;
        lg_ch.delete(); lg_inst.delete(); lg_val.delete(); lg_cyc.delete();
        repeat (20) tick();
        chk("idle no strobes", 64'(lg_ch.size()), 64'd0);
        chk("idle busy", 64'(busy[0] | busy[1]), 64'd0);

        // Clamp up/down on u0, unlimited single write on u1.
        rand_out[0] = '0; rand_out[0][2*W +: W] = 9'd100; rand_out[1] = '0;
        tgt[0] = rand_out[0]; tgt[1] = '0;
        do_reset(r);
        tgt[0][0 +: W] = 9'd20; tgt[0][2*W +: W] = 9'd90; tgt[1][1*W +: W] = 9'd300;
        wait_idle("clamp done");
        collect(0);
        chk("clamp count", 64'(g_n), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("clamp ch[%0d]", k), 64'(g_ch[k]), 64'(eb_ch[k]));
            chk($sformatf("clamp val[%0d]", k), 64'(g_val[k]), 64'(eb_val[k]));
            chk($sformatf("clamp cyc[%0d]", k), 64'(g_cyc[k] - r), 64'(eb_off[k]));
        end
        chk("clamp ready", 64'(rdy[0]), 64'hF);
        chk("clamp all_ready", 64'(allr[0]), 64'd1);
        collect(1);
        chk("unlim count", 64'(g_n), 64'd1);
        chk("unlim ch", 64'(g_ch[0]), 64'd1);
        chk("unlim val", 64'(g_val[0]), 64'd300);
        chk("unlim cyc", 64'(g_cyc[0] - r), 64'd4);

        // Interleave ch1/ch3 on u0.
        rand_out[0] = '0; rand_out[1] = '0; tgt[0] = '0; tgt[1] = '0;
        do_reset(r);
        tgt[0][1*W +: W] = 9'd24; tgt[0][3*W +: W] = 9'd24;
        wait_idle("interleave done");
        collect(0);
        chk("ilv count", 64'(g_n), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("ilv ch[%0d]", k), 64'(g_ch[k]), 64'(ec_ch[k]));
            chk($sformatf("ilv val[%0d]", k), 64'(g_val[k]), 64'(ec_val[k]));
            chk($sformatf("ilv cyc[%0d]", k), 64'(g_cyc[k] - r), 64'(4 + 9 * k));
        end

        // Readback check: primitive ignores writes to u0 ch2.
        tgt[0] = '0;
        do_reset(r);
        ig0 = 4'b0100;
        tgt[0][2*W +: W] = 9'd5;
        wait_log(0, 2, 0, idx);
        chk("verify first wr cyc", 64'(lg_cyc[(idx < 0) ? 0 : idx] - r), 64'd5);
        repeat (SETTLE + 1) tick();
        chk("verify set", 64'(verr[0][2]), 64'(EXP_V));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("verify cleared", 64'(verr[0]), 64'd0);
        wait_log(0, 2, idx + 1, idx);
        repeat (SETTLE + 1) tick();
        chk("verify reset again", 64'(verr[0][2]), 64'(EXP_V));
        ig0 = '0;

        // Reset in the middle of SETTLE.
        tgt[0] = '0;
        do_reset(r);
        tgt[0][0 +: W] = 9'd8;
        wait_log(0, 0, 0, idx);
        chk("midrst wr cyc", 64'(cyc - r), 64'd3);
        repeat (2) tick();
        rstb = 1'b0;
        tgt[0][0 +: W] = 9'd16;
        l0 = lg_ch.size();
        tick();
        chk("midrst set_value", 64'(setv[0]), 64'd0);
        chk("midrst busy", 64'(busy[0]), 64'd0);
        repeat (2) tick();
        rstb = 1'b1;
        r2 = cyc;
        wait_log(0, 0, l0, idx);
        chk("midrst next idx", 64'(idx), 64'(l0));
        chk("midrst next cyc", 64'(lg_cyc[(idx < 0) ? 0 : idx] - r2), 64'd3);
        chk("midrst next val", 64'(lg_val[(idx < 0) ? 0 : idx]), 64'd8);
        wait_idle("midrst done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
